// File: rtl/riscv_ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ex_pkg
//  Description : Shared encodings and ALU-control decode for the RV32 EX stage.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_ex_pkg;

   localparam int unsigned C_XLEN = 32;

   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] C_ALUOP_ITYPE = 2'b11;

   localparam logic [9:0] C_F73_ADD = 10'b0000000_000;
   localparam logic [9:0] C_F73_SUB = 10'b0100000_000;
   localparam logic [9:0] C_F73_AND = 10'b0000000_111;
   localparam logic [9:0] C_F73_XOR = 10'b0000000_100;
   localparam logic [9:0] C_F73_SLL = 10'b0000000_001;
   localparam logic [9:0] C_F73_MUL = 10'b0000001_000;

   localparam logic [2:0] C_F3_ADDI = 3'b000;
   localparam logic [2:0] C_F3_SRAI = 3'b101;
   localparam logic [6:0] C_F7_SRA  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_XOR  = 3'd3,
      ALU_SLL  = 3'd4,
      ALU_SRA  = 3'd5,
      ALU_MUL  = 3'd6,
      ALU_NONE = 3'd7
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   // For I-type, the funct7 slot carries imm[11:5], which distinguishes srai.
   function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop,
                                            input logic [9:0] f73);
      alu_ctrl_e ctrl;
      ctrl = ALU_NONE;
      case (aluop)
         C_ALUOP_ADD: ctrl = ALU_ADD;
         C_ALUOP_SUB: ctrl = ALU_SUB;
         C_ALUOP_RTYPE: begin
            case (f73)
               C_F73_ADD: ctrl = ALU_ADD;
               C_F73_SUB: ctrl = ALU_SUB;
               C_F73_AND: ctrl = ALU_AND;
               C_F73_XOR: ctrl = ALU_XOR;
               C_F73_SLL: ctrl = ALU_SLL;
               C_F73_MUL: ctrl = ALU_MUL;
               default:   ctrl = ALU_NONE;
            endcase
         end
         default: begin
            if (f73[2:0] == C_F3_ADDI)
               ctrl = ALU_ADD;
            else if (f73[2:0] == C_F3_SRAI && f73[9:3] == C_F7_SRA)
               ctrl = ALU_SRA;
         end
      endcase
      return ctrl;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iter_mul32.sv
`default_nettype none
// ============================================================================
//  Module      : iter_mul32
//  Description : Iterative shift-add multiplier, low XLEN bits of the product.
//  Revision    : 1.0  initial release
// ============================================================================
module iter_mul32
   import riscv_ex_pkg::*;
#(
   parameter int XLEN       = C_XLEN,
   parameter int MUL_CYCLES = XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CW = $clog2(MUL_CYCLES);

   mul_state_e      r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_mcand;
   logic [XLEN-1:0] r_mplier;
   logic [XLEN-1:0] r_prod;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= MUL_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
      end else begin
         case (r_state)
            MUL_IDLE: begin
               if (start) begin
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_prod   <= '0;
                  r_cnt    <= '0;
                  r_state  <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               if (r_mplier[0])
                  r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CW'(MUL_CYCLES - 1))
                  r_state <= MUL_DONE;
            end
            MUL_DONE: r_state <= MUL_IDLE;
            default:  r_state <= MUL_IDLE;
         endcase
      end
   end

   assign busy    = (r_state == MUL_BUSY);
   assign done    = (r_state == MUL_DONE);
   assign product = r_prod;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_stage
//  Description : RV32 execute stage with forwarding, ALU, MUL and EX/MEM reg.
//                FAST_MUL_EN selects a single-cycle multiplier (no stall).
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv_stage
   import riscv_ex_pkg::*;
#(
   parameter int XLEN       = C_XLEN,
   parameter int MUL_CYCLES = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            RegWrite_i,
   input  logic            MemtoReg_i,
   input  logic            MemRead_i,
   input  logic            MemWrite_i,
   input  logic [1:0]      ALUOp_i,
   input  logic            ALUSrc_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic [XLEN-1:0] ImmGen_i,
   input  logic [9:0]      funct_7_3_i,
   input  logic [4:0]      RS1addr_i,
   input  logic [4:0]      RS2addr_i,
   input  logic [4:0]      RDaddr_i,
   input  logic            EXMEM_RegWrite_i,
   input  logic [4:0]      EXMEM_RDaddr_i,
   input  logic [XLEN-1:0] EXMEM_ALUResult_i,
   input  logic            MEMWB_RegWrite_i,
   input  logic [4:0]      MEMWB_RDaddr_i,
   input  logic [XLEN-1:0] MEMWB_WBdata_i,
   output logic            RegWrite_o,
   output logic            MemtoReg_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic [XLEN-1:0] ALUResult_o,
   output logic [XLEN-1:0] MemWdata_o,
   output logic [4:0]      RDaddr_o,
   output logic            stall_o
);

   logic [XLEN-1:0] w_rs1_fwd;
   logic [XLEN-1:0] w_rs2_fwd;
   logic [XLEN-1:0] w_op_b;
   logic [XLEN-1:0] w_alu_res;
   logic [XLEN-1:0] w_mul_res;
   alu_ctrl_e       w_alu_ctrl;
   logic            w_is_mul;
   logic            w_bubble;

   logic            r_regwrite;
   logic            r_memtoreg;
   logic            r_memread;
   logic            r_memwrite;
   logic [XLEN-1:0] r_alu_result;
   logic [XLEN-1:0] r_mem_wdata;
   logic [4:0]      r_rd_addr;

   // EX/MEM has priority over MEM/WB; x0 never forwards.
   always_comb begin
      w_rs1_fwd = RS1data_i;
      if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == RS1addr_i)
         w_rs1_fwd = EXMEM_ALUResult_i;
      else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS1addr_i)
         w_rs1_fwd = MEMWB_WBdata_i;
   end

   always_comb begin
      w_rs2_fwd = RS2data_i;
      if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == RS2addr_i)
         w_rs2_fwd = EXMEM_ALUResult_i;
      else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS2addr_i)
         w_rs2_fwd = MEMWB_WBdata_i;
   end

   assign w_op_b     = ALUSrc_i ? ImmGen_i : w_rs2_fwd;
   assign w_alu_ctrl = alu_decode(ALUOp_i, funct_7_3_i);
   assign w_is_mul   = (w_alu_ctrl == ALU_MUL);

   always_comb begin
      w_alu_res = '0;
      case (w_alu_ctrl)
         ALU_ADD: w_alu_res = w_rs1_fwd + w_op_b;
         ALU_SUB: w_alu_res = w_rs1_fwd - w_op_b;
         ALU_AND: w_alu_res = w_rs1_fwd & w_op_b;
         ALU_XOR: w_alu_res = w_rs1_fwd ^ w_op_b;
         ALU_SLL: w_alu_res = w_rs1_fwd << w_op_b[4:0];
         ALU_SRA: w_alu_res = $signed(w_rs1_fwd) >>> w_op_b[4:0];
         ALU_MUL: w_alu_res = w_mul_res;
         default: w_alu_res = '0;
      endcase
   end

`ifdef FAST_MUL_EN
   assign w_mul_res = w_rs1_fwd * w_rs2_fwd;
   assign w_bubble  = 1'b0;
   assign stall_o   = 1'b0;
`else
   logic w_mul_busy;
   logic w_mul_done;
   logic w_mul_start;

   // Operands are sampled only when the multiplier is idle, so producers
   // draining through MEM/WB during the stall cannot disturb them.
   assign w_mul_start = w_is_mul && !w_mul_busy && !w_mul_done;

   iter_mul32 #(
      .XLEN       (XLEN),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_iter_mul32 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (w_mul_start),
      .a       (w_rs1_fwd),
      .b       (w_rs2_fwd),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_mul_res)
   );

   assign w_bubble = w_is_mul && !w_mul_done;
   assign stall_o  = w_mul_start || w_mul_busy;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i || w_bubble) begin
         r_regwrite   <= 1'b0;
         r_memtoreg   <= 1'b0;
         r_memread    <= 1'b0;
         r_memwrite   <= 1'b0;
         r_alu_result <= '0;
         r_mem_wdata  <= '0;
         r_rd_addr    <= '0;
      end else begin
         r_regwrite   <= RegWrite_i;
         r_memtoreg   <= MemtoReg_i;
         r_memread    <= MemRead_i;
         r_memwrite   <= MemWrite_i;
         r_alu_result <= w_alu_res;
         r_mem_wdata  <= w_rs2_fwd;
         r_rd_addr    <= RDaddr_i;
      end
   end

   assign RegWrite_o  = r_regwrite;
   assign MemtoReg_o  = r_memtoreg;
   assign MemRead_o   = r_memread;
   assign MemWrite_o  = r_memwrite;
   assign ALUResult_o = r_alu_result;
   assign MemWdata_o  = r_mem_wdata;
   assign RDaddr_o    = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_stage
//  Description : Directed self-checking bench for ex_muldiv_stage.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_muldiv_stage;

   typedef struct packed {
      logic        rw, mtr, mr, mw;
      logic [1:0]  op;
      logic        alusrc;
      logic [31:0] rs1d, rs2d, imm;
      logic [9:0]  f73;
      logic [4:0]  rs1, rs2, rd;
   } instr_t;

   logic clk = 1'b0;
   logic rst;
   instr_t cur;
   logic exm_rw_d, mwb_rw_d;
   logic [4:0] exm_rd_d, mwb_rd_d;
   logic [31:0] exm_res_d, mwb_data_d;
   bit loopback;

   logic rw_o, mtr_o, mr_o, mw_o, stall;
   logic [31:0] res_o, wd_o;
   logic [4:0] rd_o;
   logic exm_rw;
   logic [4:0] exm_rd;
   logic [31:0] exm_res;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   bit chk_en = 0;

   // Model state: expected EX/MEM contents and cycles the current MUL has spent in EX.
   logic e_rw = 0, e_mtr = 0, e_mr = 0, e_mw = 0;
   logic [31:0] e_res = 0, e_wd = 0;
   logic [4:0] e_rd = 0;
   int mul_cyc = 0;
   logic [31:0] mul_a, mul_b;
   bit adv = 0;

   always #5 clk = ~clk;

   assign exm_rw  = loopback ? rw_o  : exm_rw_d;
   assign exm_rd  = loopback ? rd_o  : exm_rd_d;
   assign exm_res = loopback ? res_o : exm_res_d;

   ex_muldiv_stage dut (
      .clk_i(clk), .rst_i(rst),
      .RegWrite_i(cur.rw), .MemtoReg_i(cur.mtr), .MemRead_i(cur.mr), .MemWrite_i(cur.mw),
      .ALUOp_i(cur.op), .ALUSrc_i(cur.alusrc),
      .RS1data_i(cur.rs1d), .RS2data_i(cur.rs2d), .ImmGen_i(cur.imm),
      .funct_7_3_i(cur.f73),
      .RS1addr_i(cur.rs1), .RS2addr_i(cur.rs2), .RDaddr_i(cur.rd),
      .EXMEM_RegWrite_i(exm_rw), .EXMEM_RDaddr_i(exm_rd), .EXMEM_ALUResult_i(exm_res),
      .MEMWB_RegWrite_i(mwb_rw_d), .MEMWB_RDaddr_i(mwb_rd_d), .MEMWB_WBdata_i(mwb_data_d),
      .RegWrite_o(rw_o), .MemtoReg_o(mtr_o), .MemRead_o(mr_o), .MemWrite_o(mw_o),
      .ALUResult_o(res_o), .MemWdata_o(wd_o), .RDaddr_o(rd_o),
      .stall_o(stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] d);
      logic        frw;
      logic [4:0]  frd;
      logic [31:0] fres;
      frw  = loopback ? e_rw  : exm_rw_d;
      frd  = loopback ? e_rd  : exm_rd_d;
      fres = loopback ? e_res : exm_res_d;
      if (frw && frd != 0 && frd == addr) return fres;
      if (mwb_rw_d && mwb_rd_d != 0 && mwb_rd_d == addr) return mwb_data_d;
      return d;
   endfunction

   function automatic logic [31:0] ref_alu(input instr_t i, input logic [31:0] a, input logic [31:0] b);
      if (i.op == 2'b00) return a + b;
      if (i.op == 2'b01) return a - b;
      if (i.op == 2'b10) begin
         if (i.f73 == 10'b0000000_000) return a + b;
         if (i.f73 == 10'b0100000_000) return a - b;
         if (i.f73 == 10'b0000000_111) return a & b;
         if (i.f73 == 10'b0000000_100) return a ^ b;
         if (i.f73 == 10'b0000000_001) return a << b[4:0];
         return 32'd0;
      end
      if (i.f73[2:0] == 3'b000) return a + b;
      if (i.f73 == 10'b0100000_101) return 32'($signed(a) >>> b[4:0]);
      return 32'd0;
   endfunction

   function automatic bit ref_is_mul();
      return cur.op == 2'b10 && cur.f73 == 10'b0000001_000;
   endfunction

   function automatic bit ref_stall();
      return ref_is_mul() && mul_cyc < 33;
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] a, b2, opb;
      a   = ref_fwd(cur.rs1, cur.rs1d);
      b2  = ref_fwd(cur.rs2, cur.rs2d);
      opb = cur.alusrc ? cur.imm : b2;
      if (rst) begin
         {e_rw, e_mtr, e_mr, e_mw} = 4'b0;
         e_res = 0; e_wd = 0; e_rd = 0;
         mul_cyc = 0; adv = 1;
      end else if (ref_is_mul() && mul_cyc < 33) begin
         if (mul_cyc == 0) begin mul_a = a; mul_b = b2; end
         {e_rw, e_mtr, e_mr, e_mw} = 4'b0;
         e_res = 0; e_wd = 0; e_rd = 0;
         mul_cyc++; adv = 0;
      end else begin
         {e_rw, e_mtr, e_mr, e_mw} = {cur.rw, cur.mtr, cur.mr, cur.mw};
         e_res = ref_is_mul() ? mul_a * mul_b : ref_alu(cur, a, opb);
         e_wd  = b2;
         e_rd  = cur.rd;
         mul_cyc = 0; adv = 1;
      end
   end

   always @(negedge clk) begin
      if (stall === 1'b1) stall_cnt++;
      if (chk_en) begin
         chk("stall_o",     {31'd0, stall}, {31'd0, ref_stall()});
         chk("RegWrite_o",  {31'd0, rw_o},  {31'd0, e_rw});
         chk("MemtoReg_o",  {31'd0, mtr_o}, {31'd0, e_mtr});
         chk("MemRead_o",   {31'd0, mr_o},  {31'd0, e_mr});
         chk("MemWrite_o",  {31'd0, mw_o},  {31'd0, e_mw});
         chk("ALUResult_o", res_o, e_res);
         chk("MemWdata_o",  wd_o,  e_wd);
         chk("RDaddr_o",    {27'd0, rd_o}, {27'd0, e_rd});
      end
   end

   function automatic instr_t mk(input logic [1:0] op, input logic [9:0] f73, input logic alusrc,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
      instr_t t;
      t.rw = 1'b1; t.mtr = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
      t.op = op; t.f73 = f73; t.alusrc = alusrc;
      t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
      t.rs1d = d1; t.rs2d = d2; t.imm = imm;
      return t;
   endfunction

   // Presents one instruction and holds it until it leaves EX (bounded).
   task automatic run(input instr_t i);
      int n;
      cur = i;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!adv && n < 40);
      if (!adv) begin
         checks++; errors++;
         $display("FAIL run_timeout actual=%0d cycles required=retire", n);
      end
   endtask

   localparam logic [9:0] F_MUL = 10'b0000001_000;

   initial begin
      instr_t nop, t;
      nop = mk(2'b00, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      nop.rw = 1'b0;
      cur = nop;
      rst = 1'b1;
      loopback = 0;
      exm_rw_d = 0; exm_rd_d = 0; exm_res_d = 0;
      mwb_rw_d = 0; mwb_rd_d = 0; mwb_data_d = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset ALUResult_o", res_o, 32'd0);
      chk("reset RegWrite_o", {31'd0, rw_o}, 32'd0);
      chk("reset stall_o", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      chk_en = 1;

      // add, no hazards
      run(mk(2'b10, 10'b0000000_000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0));
      chk("add 5+7", res_o, 32'd12);
      chk("add rd", {27'd0, rd_o}, 32'd4);

      // double hazard: EX/MEM wins
      exm_rw_d = 1; exm_rd_d = 5'd3; exm_res_d = 32'h10;
      mwb_rw_d = 1; mwb_rd_d = 5'd3; mwb_data_d = 32'h20;
      run(mk(2'b11, 10'b0000000_000, 1'b1, 5'd3, 5'd0, 5'd7, 32'h55, 32'd0, 32'd1));
      chk("addi exmem prio", res_o, 32'h11);
      exm_rw_d = 0;
      run(mk(2'b11, 10'b0000000_000, 1'b1, 5'd3, 5'd0, 5'd7, 32'h55, 32'd0, 32'd1));
      chk("addi memwb fwd", res_o, 32'h21);
      exm_rw_d = 1; exm_rd_d = 5'd0; mwb_rd_d = 5'd0;
      run(mk(2'b11, 10'b0000000_000, 1'b1, 5'd0, 5'd0, 5'd7, 32'h100, 32'd0, 32'd1));
      chk("addi x0 no fwd", res_o, 32'h101);
      exm_rw_d = 0; mwb_rw_d = 0;

      run(mk(2'b10, 10'b0100000_000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd20, 32'd7, 32'd0));
      chk("sub", res_o, 32'd13);
      run(mk(2'b01, 10'b0000000_000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd5, 32'd0));
      chk("branch sub", res_o, 32'hFFFF_FFFE);
      run(mk(2'b10, 10'b0000000_111, 1'b0, 5'd1, 5'd2, 5'd4, 32'hF0F0, 32'hFF00, 32'd0));
      chk("and", res_o, 32'hF000);
      run(mk(2'b10, 10'b0000000_100, 1'b0, 5'd1, 5'd2, 5'd4, 32'hFF, 32'h0F, 32'd0));
      chk("xor", res_o, 32'hF0);
      run(mk(2'b10, 10'b0000000_010, 1'b0, 5'd1, 5'd2, 5'd4, 32'hFF, 32'h0F, 32'd0));
      chk("undefined", res_o, 32'd0);
      t = mk(2'b00, 10'b0000000_010, 1'b1, 5'd1, 5'd2, 5'd9, 32'h1000, 32'hAB, 32'h10);
      t.mr = 1'b1; t.mtr = 1'b1;
      run(t);
      chk("ld addr", res_o, 32'h1010);
      chk("ld MemRead_o", {31'd0, mr_o}, 32'd1);
      run(mk(2'b11, 10'b0100000_101, 1'b1, 5'd1, 5'd0, 5'd8, 32'h8000_0000, 32'd0, 32'h404));
      chk("srai", res_o, 32'hF800_0000);
      run(mk(2'b10, 10'b0000000_001, 1'b0, 5'd1, 5'd2, 5'd8, 32'd1, 32'd31, 32'd0));
      chk("sll", res_o, 32'h8000_0000);

      // iterative multiply
      stall_cnt = 0;
      run(mk(2'b10, F_MUL, 1'b0, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFF, 32'd3, 32'd0));
      chk("mul result", res_o, 32'hFFFF_FFFD);
      chk("mul RegWrite_o", {31'd0, rw_o}, 32'd1);
      chk("mul stall cycles", stall_cnt, 32'd33);

      // reset while busy
      cur = mk(2'b10, F_MUL, 1'b0, 5'd1, 5'd2, 5'd9, 32'd6, 32'd7, 32'd0);
      repeat (11) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cur = nop;
      #1;
      chk("abort ALUResult_o", res_o, 32'd0);
      chk("abort RDaddr_o", {27'd0, rd_o}, 32'd0);
      chk("abort stall_o", {31'd0, stall}, 32'd0);
      run(nop);
      run(mk(2'b10, F_MUL, 1'b0, 5'd1, 5'd2, 5'd5, 32'd6, 32'd7, 32'd0));
      chk("mul 6x7", res_o, 32'd42);

      // MUL followed by a dependent add via EX/MEM loopback
      loopback = 1;
      run(nop);
      run(mk(2'b10, F_MUL, 1'b0, 5'd1, 5'd2, 5'd5, 32'd6, 32'd7, 32'd0));
      run(mk(2'b10, 10'b0000000_000, 1'b0, 5'd5, 5'd0, 5'd6, 32'hDEAD, 32'd100, 32'd0));
      chk("dep add", res_o, 32'd142);
      chk("dep add no restall", {31'd0, stall}, 32'd0);
      run(nop);
      run(nop);
      loopback = 0;

      chk_en = 0;
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline, fed directly by the ID/EX register outputs.
- Contains the forwarding mux, ALU control decode, ALU and an iterative 32-cycle shift-add multiplier for MUL.
- Ends in the EX/MEM pipeline register.
- Asserts stall_o while a multiply is in flight. Hazard logic uses stall_o to freeze PC, IF/ID and ID/EX.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, iterations of the multiplier; must equal XLEN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control signals from ID/EX
- ALUOp_i  in  2  00=add (ld/st), 01=sub (branch), 10=R-type, 11=I-type
- ALUSrc_i  in  1  1 selects ImmGen_i as operand B
- RS1data_i, RS2data_i, ImmGen_i  in  32 each  operands from ID/EX
- funct_7_3_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  register addresses
- EXMEM_RegWrite_i  in  1  forwarding source, EX/MEM stage write enable
- EXMEM_RDaddr_i  in  5  forwarding source, EX/MEM destination
- EXMEM_ALUResult_i  in  32  forwarding source, EX/MEM result
- MEMWB_RegWrite_i  in  1  forwarding source, MEM/WB stage write enable
- MEMWB_RDaddr_i  in  5  forwarding source, MEM/WB destination
- MEMWB_WBdata_i  in  32  forwarding source, MEM/WB write-back data
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  EX/MEM registered control
- ALUResult_o  out  32  EX/MEM registered result
- MemWdata_o  out  32  EX/MEM registered, forwarded rs2 value
- RDaddr_o  out  5  EX/MEM registered destination
- stall_o  out  1  combinational; freeze upstream stages

Behaviour:
- Reset: every registered output is 0, FSM returns to IDLE, counter and multiplier registers are cleared. Reset mid-multiply aborts the operation with no result written.

Forwarding (per operand):
- Select EX/MEM if EXMEM_RegWrite_i is set, EXMEM_RDaddr_i != 0 and it equals the source address.
- Else select MEM/WB under the same rule.
- Else use the ID/EX data.
- EX/MEM has priority over MEM/WB.
- Operand B = ALUSrc_i ? ImmGen_i : forwarded rs2. MemWdata_o always takes forwarded rs2.

ALU decode:
- ALUOp 00 → add. ALUOp 01 → sub.
- ALUOp 10, by funct_7_3_i: 0000000_000 add, 0100000_000 sub, 0000000_111 and, 0000000_100 xor, 0000000_001 sll (shamt = B[4:0]), 0000001_000 mul.
- ALUOp 11: funct3 000 addi; funct3 101 with imm[11:5]=0100000 srai (arithmetic).
- Any undefined encoding → result 0.
- Arithmetic is mod 2^32; no overflow flag.

Non-MUL op:
- Single cycle. At the next posedge, EX/MEM captures the result, control signals and RDaddr. stall_o = 0.

MUL FSM (IDLE, BUSY, DONE):
- IDLE: a MUL decode asserts stall_o combinationally. At the clock edge: latch forwarded operands into multiplicand/multiplier, clear the product, cnt=0, go to BUSY. EX/MEM captures a bubble (all control 0, data 0).
- BUSY: stall_o=1. Each cycle: if multiplier[0] is set, product += multiplicand; then multiplicand <<= 1 and multiplier >>= 1; cnt++. At cnt==MUL_CYCLES-1 go to DONE. EX/MEM captures a bubble every cycle.
- DONE: stall_o=0. EX/MEM captures product[31:0] plus the MUL's control and RDaddr. Next state is IDLE. The same ID/EX instruction must not retrigger; the DONE→IDLE edge coincides with ID/EX advancing.
- Latency: MUL enters EX at cycle 0. stall_o is high for cycles 0..32 (33 cycles). The result is visible on the EX/MEM outputs after the edge ending cycle 33.
- The result is the low 32 bits, identical for signed and unsigned operands.
- Forwarded operands are sampled only in IDLE, so older producers draining through MEM/WB during a stall do not corrupt them.
- A MUL with rd=0: the result is computed, and RDaddr_o=0 is passed through unchanged.

Optional Feature:
- Macro FAST_MUL_EN.
- Defined: MUL is a single-cycle combinational multiply, the FSM is removed and stall_o is tied to 0.
- Undefined: iterative FSM as described above.

Decomposition:
- Package riscv_ex_pkg holds:
  - ALUOp encodings
  - internal ALU-control enum
  - funct_7_3 constants
  - FSM state enum
  - XLEN default
- Sub-module iter_mul32 holds the FSM, counter and shift-add datapath, with ports: start, a, b, busy, done, product.

Test Plan:
- add with no hazards: rs1=5, rs2=7 → ALUResult_o=12 one cycle later; stall_o never asserted.
- Double hazard: EX/MEM rd=3 holds 0x10 and MEM/WB rd=3 holds 0x20; instruction addi rs1=3, imm=1 → result 0x11 (EX/MEM priority). Repeat with rd=0 in both stages → original RS1data used.
- MUL 0xFFFFFFFF × 3 → stall_o high for exactly 33 cycles, EX/MEM shows bubbles, then ALUResult_o=0xFFFFFFFD with RegWrite_o=1.
- Reset asserted at BUSY cycle 10 → next edge: all outputs 0, stall_o=0; a subsequent MUL 6×7 yields 42.
- srai with rs1=0x80000000, shamt 4 → 0xF8000000. sll with rs1=1, rs2=31 → 0x80000000.
- MUL back-to-back with a dependent add (rs1 = MUL rd): add sees the product via EX/MEM forwarding; no retrigger of the MUL.
